// File: rtl/dist_fifo_fwft_pkg.sv
// Shared types for the distributed-RAM FWFT FIFO.
// Encodes which of push/pop were accepted on an edge.
package dist_fifo_fwft_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/dist_fifo_fwft_if.sv
// Push/pop bus of the FWFT FIFO.
// master = producer/consumer side, slave = FIFO side.
interface dist_fifo_fwft_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] d_in;
  logic             wr_en;
  logic [WIDTH-1:0] d_out;
  logic             rd_en;
  logic             full;
  logic             empty;
  logic             afull;
  logic             aempty;

  modport master (
    output d_in, wr_en, rd_en,
    input  d_out, full, empty, afull, aempty
  );

  modport slave (
    input  d_in, wr_en, rd_en,
    output d_out, full, empty, afull, aempty
  );
endinterface

// File: rtl/dist_fifo_fwft_ram.sv
// Simple dual-port distributed RAM.
// Synchronous write, asynchronous read.
module dist_fifo_ram #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 32,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  // write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dist_fifo_fwft.sv
// First-word-fall-through FIFO on distributed RAM.
// Flags decode from the registered count only.
module dist_fifo_fwft
  import dist_fifo_fwft_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 32,
  parameter int ID    = 0
) (
  input logic           clk,
  input logic           reset,
  dist_fifo_fwft_if.slave bus
);

  localparam int ADDR_W       = $clog2(SIZE);
  localparam int AFULL_LEVEL  = SIZE - 4;
  localparam int AEMPTY_LEVEL = 4;

  localparam logic [ADDR_W:0] CNT_FULL =
    (ADDR_W+1)'(SIZE);
  localparam logic [ADDR_W:0] CNT_AFULL =
    (ADDR_W+1)'(AFULL_LEVEL);
  localparam logic [ADDR_W:0] CNT_AEMPTY =
    (ADDR_W+1)'(AEMPTY_LEVEL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_ok, rd_ok;
  op_e               op;

  assign wr_ok = bus.wr_en & ~bus.full;
  assign rd_ok = bus.rd_en & ~bus.empty;
  assign op    = op_e'({wr_ok, rd_ok});

  dist_fifo_ram #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr_q),
    .wdata(bus.d_in),
    .raddr(rd_ptr_q),
    .rdata(bus.d_out)
  );

  // next pointers and occupancy from accepted ops
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OP_WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      OP_RD: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      OP_NONE: ;
    endcase
  end

  // state registers, reset dominates
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // misuse notes for simulation logs
  always_ff @(posedge clk) begin
    if (!reset && bus.wr_en && bus.full)
      $info("dist_fifo %0d: overflow", ID);
    if (!reset && bus.rd_en && bus.empty)
      $info("dist_fifo %0d: underflow", ID);
  end

  assign bus.full   = (count_q == CNT_FULL);
  assign bus.empty  = (count_q == '0);
  assign bus.afull  = (count_q >= CNT_AFULL);
  assign bus.aempty = (count_q <= CNT_AEMPTY);

endmodule

// File: tb/tb_dist_fifo_fwft.sv
// Randomized bench for dist_fifo_fwft.
// Reference is a plain queue of words.
module tb_dist_fifo_fwft;

  localparam int W = 34;
  localparam int S = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] model_q [$];

  always #5 clk = ~clk;

  dist_fifo_fwft_if #(.WIDTH(W)) bus ();

  dist_fifo_fwft #(
    .WIDTH(W),
    .SIZE (S),
    .ID   (0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".empty"},  W'(bus.empty),  W'(n == 0));
    chk({tag, ".full"},   W'(bus.full),   W'(n == S));
    chk({tag, ".afull"},  W'(bus.afull),  W'(n >= S - 4));
    chk({tag, ".aempty"}, W'(bus.aempty), W'(n <= 4));
    if (n != 0)
      chk({tag, ".dout"}, bus.d_out, model_q[0]);
  endtask

  // one clock: drive, apply queue rules, check
  task automatic step(input logic rst,
                      input logic wr,
                      input logic [W-1:0] din,
                      input logic rd,
                      input string tag);
    bit do_rd, do_wr;
    @(negedge clk);
    reset     = rst;
    bus.wr_en = wr;
    bus.d_in  = din;
    bus.rd_en = rd;
    do_rd = rd && (model_q.size() > 0);
    do_wr = wr && (model_q.size() < S);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(din);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] v;
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.d_in  = '0;

    step(1, 0, '0, 0, "rst0");
    step(1, 0, '0, 0, "rst1");
    step(0, 0, '0, 0, "idle");

    v = 34'h1_0000_0005;
    step(0, 1, v, 0, "fwft_wr");
    step(0, 0, '0, 0, "fwft_hold");
    chk("fwft_val", bus.d_out, v);
    step(0, 0, '0, 1, "fwft_pop");
    chk("fwft_empty", W'(bus.empty), W'(1));

    for (int i = 0; i < S; i++)
      step(0, 1, W'(i), 0, "fill");
    chk("fill_full", W'(bus.full), W'(1));
    step(0, 1, W'(99), 0, "ovf");
    for (int i = 0; i < S; i++) begin
      chk("drain_seq", bus.d_out, W'(i));
      step(0, 0, '0, 1, "drain");
    end
    chk("drain_empty", W'(bus.empty), W'(1));

    for (int i = 0; i < 5; i++)
      step(0, 1, W'($urandom()), 0, "pre5");
    for (int i = 0; i < 10; i++)
      step(0, 1, {2'b10, 32'($urandom())}, 1, "rw5");
    chk("rw5_cnt", W'(model_q.size()), W'(5));
    for (int i = 0; i < 5; i++)
      step(0, 0, '0, 1, "flush5");

    step(0, 0, '0, 1, "unf");
    step(0, 1, W'(34'h2_AAAA_5555), 1, "rw_empty");
    chk("rw_empty_val", bus.d_out, W'(34'h2_AAAA_5555));
    for (int i = 1; i < S; i++)
      step(0, 1, W'(i + 100), 0, "fill2");
    step(0, 1, W'(34'h3_DEAD_BEEF), 1, "rw_full");
    chk("rw_full_cnt", W'(model_q.size()), W'(S - 1));
    for (int i = 0; i < S - 1; i++)
      step(0, 0, '0, 1, "drain2");

    for (int i = 0; i < 100; i++) begin
      logic wr, rd;
      wr = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 9) < 5);
      step(0, wr, W'({$urandom(), $urandom()}),
           rd, "rand");
      if ($urandom_range(0, 3) == 0)
        step(0, 0, '0, 0, "gap");
    end

    while (model_q.size() > 0)
      step(0, 0, '0, 1, "drain3");
    for (int i = 0; i < 10; i++)
      step(0, 1, W'(i + 500), 0, "pre10");
    step(1, 0, '0, 0, "mid_rst");
    chk("mid_rst_empty", W'(bus.empty), W'(1));
    step(0, 1, W'(7), 0, "post_rst");
    chk("post_rst_val", bus.d_out, W'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
